// File: rtl/mdio_responder_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: FSM states, opcodes and
// the fixed PHY identifier register addresses.
package mdio_responder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RD_DATA,
        S_WR_DATA
    } state_e;

    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [4:0] REG_PHYID1 = 5'd2;
    localparam logic [4:0] REG_PHYID2 = 5'd3;

    function automatic logic is_id_reg(input logic [4:0] addr);
        return (addr == REG_PHYID1) || (addr == REG_PHYID2);
    endfunction

endpackage

// File: rtl/mdio_responder_mdc_edge_sync.sv
// Two-flop synchronizers for MDC/MDIO plus registered MDC edge pulses; the
// MDIO output is delayed one more flop so it lines up with the edge pulses.
module mdc_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);

    logic [2:0] mdc_sync_q, mdc_sync_d;
    logic [2:0] mdio_sync_q, mdio_sync_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[1:0], mdc};
        mdio_sync_d = {mdio_sync_q[1:0], mdio_i};
        rise_d      = mdc_sync_q[1] & ~mdc_sync_q[2];
        fall_d      = ~mdc_sync_q[1] & mdc_sync_q[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign mdc_rise = rise_q;
    assign mdc_fall = fall_q;
    assign mdio_s   = mdio_sync_q[2];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: decodes read/write frames addressed to PHY_ADDR from
// oversampled MDC/MDIO and serves a 32x16 register file with fixed PHY ID regs.
module mdio_responder
    import mdio_responder_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR  = 5'd1,
    parameter int unsigned PRE_LEN   = 32,
    parameter logic [15:0] PHY_ID1   = 16'h0141,
    parameter logic [15:0] PHY_ID2   = 16'h0CC2,
    parameter logic [15:0] REG0_INIT = 16'h1140,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        reg_wstrobe,
    output logic [4:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]    PRE_MAX = 6'(PRE_LEN);

    logic mdc_rise, mdc_fall, bit_in;

    mdc_edge_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_s   (bit_in)
    );

    state_e         state_q, state_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [5:0]     pre_cnt_q, pre_cnt_d;
    logic [1:0]     op_q, op_d;
    logic [4:0]     phyad_q, phyad_d;
    logic [4:0]     regad_q, regad_d;
    logic [15:0]    sh_q, sh_d;
    logic           oe_q, oe_d;
    logic           o_q, o_d;
    logic           wstrobe_q, wstrobe_d;
    logic [4:0]     waddr_q, waddr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [15:0]    regs_q [32];

    logic           rf_we;
    logic [4:0]     rf_addr;
    logic [15:0]    rf_wdata;
    logic [4:0]     ra_next;
    logic [15:0]    rd_val;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        op_d      = op_q;
        phyad_d   = phyad_q;
        regad_d   = regad_q;
        sh_d      = sh_q;
        oe_d      = oe_q;
        o_d       = o_q;
        wstrobe_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        to_cnt_d  = to_cnt_q;
        rf_we     = 1'b0;
        rf_addr   = regad_q;
        rf_wdata  = {sh_q[14:0], bit_in};
        ra_next   = {regad_q[3:0], bit_in};
        rd_val    = regs_q[ra_next];
        if (ra_next == REG_PHYID1) begin
            rd_val = PHY_ID1;
        end else if (ra_next == REG_PHYID2) begin
            rd_val = PHY_ID2;
        end

        unique case (state_q)
            S_IDLE: begin
                if (mdc_rise) begin
                    if (bit_in) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PRE_MAX) begin
                        state_d = S_ST;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
            end
            S_ST: begin
                if (mdc_rise) begin
                    if (bit_in) begin
                        state_d   = S_OP;
                        bit_cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_OP: begin
                if (mdc_rise) begin
                    op_d      = {op_q[0], bit_in};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        if (op_d == OP_READ || op_d == OP_WRITE) begin
                            state_d = S_PHYAD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_PHYAD: begin
                if (mdc_rise) begin
                    phyad_d   = {phyad_q[3:0], bit_in};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        state_d   = S_REGAD;
                    end
                end
            end
            S_REGAD: begin
                if (mdc_rise) begin
                    regad_d   = ra_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        sh_d      = rd_val;
                        state_d   = (phyad_q == PHY_ADDR) ? S_TA : S_IDLE;
                    end
                end
            end
            S_TA: begin
                if (op_q == OP_READ) begin
                    // bit_cnt==1 means the first TA bit has been seen; drive from the next fall
                    if (mdc_fall && bit_cnt_q == 5'd1) begin
                        oe_d = 1'b1;
                        o_d  = 1'b0;
                    end
                    if (mdc_rise) begin
                        if (bit_cnt_q == 5'd0) begin
                            bit_cnt_d = 5'd1;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = S_RD_DATA;
                        end
                    end
                end else if (mdc_rise) begin
                    if (bit_cnt_q == 5'd0) begin
                        if (bit_in) begin
                            bit_cnt_d = 5'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (bit_in) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_WR_DATA;
                    end
                end
            end
            S_RD_DATA: begin
                if (mdc_fall) begin
                    if (bit_cnt_q == 5'd16) begin
                        state_d = S_IDLE;
                    end else begin
                        o_d       = sh_q[15];
                        sh_d      = {sh_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_WR_DATA: begin
                if (mdc_rise) begin
                    sh_d      = rf_wdata;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        rf_we     = !is_id_reg(regad_q);
                        wstrobe_d = 1'b1;
                        waddr_d   = regad_q;
                        wdata_d   = rf_wdata;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (mdc_rise || mdc_fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        // Every exit to IDLE (normal end or abort) releases the pad and restarts preamble counting
        if (state_d == S_IDLE) begin
            oe_d      = 1'b0;
            o_d       = 1'b1;
            bit_cnt_d = '0;
            if (state_q != S_IDLE) pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            op_q      <= '0;
            phyad_q   <= '0;
            regad_q   <= '0;
            sh_q      <= '0;
            oe_q      <= 1'b0;
            o_q       <= 1'b1;
            wstrobe_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            op_q      <= op_d;
            phyad_q   <= phyad_d;
            regad_q   <= regad_d;
            sh_q      <= sh_d;
            oe_q      <= oe_d;
            o_q       <= o_d;
            wstrobe_q <= wstrobe_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 0) ? REG0_INIT : '0;
            end
        end else if (rf_we) begin
            regs_q[rf_addr] <= rf_wdata;
        end
    end

    assign mdio_o      = o_q;
    assign mdio_oe     = oe_q;
    assign reg_wstrobe = wstrobe_q;
    assign reg_waddr   = waddr_q;
    assign reg_wdata   = wdata_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
